ps2_scancode_fifo: RTL and testbench

//  Parametrised PS/2 keyboard receiver: synchronises PS2_CLK/PS2_DAT, validates each 11-bit frame
//  (start, 8 data LSB-first, odd parity, stop), folds E0/F0 prefixes into one key event, and buffers

---
 rtl/ps2_scancode_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_scancode_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_fifo.sv
// ps2_scancode_fifo
//   PS/2 keyboard receiver. It synchronises PS2_CLK and PS2_DAT, checks each
//   11-bit frame (start, 8 data bits LSB-first, odd parity, stop) and merges
//   E0/F0 prefix bytes into a single key event. Events are held in a
//   first-word-fall-through FIFO that the consumer drains with valid/ready.
// Ports
//   CLOCK_50, Resetn        system clock; synchronous active-low reset
//   PS2_CLK, PS2_DAT        asynchronous keyboard lines (inputs only)
//   evt_code/break/ext      head event fields, forced to 0 while the FIFO is empty
//   evt_valid, evt_ready    head handshake; the head is popped when both are 1
//   fifo_count              number of entries held, 0..FIFO_DEPTH
//   overflow, err_clr       sticky dropped-event flag and its clear input
//   frame_err               one-cycle pulse on a parity, start, stop or timeout error
//
// state  | meaning
// IDLE   | waiting for a start bit (DAT=0 at a falling edge)
// DATA   | shifting in data bits 0..7
// PARITY | capturing the parity bit
// STOP   | checking the stop bit and parity, then back to IDLE
module ps2_scancode_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          Resetn,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   acc_q, acc_d;
  logic                   ferr_q, ferr_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic clk_s, dat_s, fall;
  logic push, pop, wr, full, empty;
  logic [9:0] head;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
    clk_prev_d = clk_s;
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    acc_d      = 1'b0;
    ferr_d     = 1'b0;

    if (state_q == S_IDLE || fall) tmo_d = '0;
    else                           tmo_d = tmo_q + TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (fall && !dat_s) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shreg_d[bitcnt_q] = dat_s;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (dat_s && (^{shreg_q, par_q})) acc_d = 1'b1;
          else                              ferr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Too long without a falling edge inside a frame: abandon it.
    if (state_q != S_IDLE && !fall && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  // The accepted byte is read straight from shreg_q one cycle after
  // acceptance; shreg_q cannot change again until the next frame's data bits.
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (acc_q) begin
      if (shreg_q == 8'hE0)      ext_d = 1'b1;
      else if (shreg_q == 8'hF0) brk_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = evt_ready & ~empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign wr    = push & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr) begin
      mem_d[wr_ptr_q] = {ext_q, brk_q, shreg_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr && pop) count_d = count_q - CNT_W'(1);
    if (push && full && !pop) ovf_d = 1'b1;
    else if (err_clr)         ovf_d = 1'b0;
  end

  assign head       = mem_q[rd_ptr_q];
  assign evt_valid  = ~empty;
  assign evt_code   = empty ? 8'h00 : head[7:0];
  assign evt_break  = empty ? 1'b0  : head[8];
  assign evt_ext    = empty ? 1'b0  : head[9];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      acc_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      ferr_q     <= ferr_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: table of frames with expected events, hand
// sequences for latency/overflow/timeout/reset, then random frames against
// a queue-based prefix/event model with a random consumer.
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 8;   // CLOCK_50 cycles per PS2_CLK half period

  logic       CLOCK_50 = 1'b0;
  logic       Resetn = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] evt_code;
  logic       evt_break, evt_ext, evt_valid;
  logic       evt_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overflow, frame_err;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_wide = 0;
  logic ferr_prev = 1'b0;

  ps2_scancode_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (frame_err) begin
      err_seen <= err_seen + 1;
      if (ferr_prev) err_wide <= err_wide + 1;
    end
    ferr_prev <= frame_err;
  end

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    int         exp_err;
    bit         exp_valid;
    logic [7:0] exp_code;
    bit         exp_brk;
    bit         exp_ext;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    bit         brk;
    bit         ext;
  } evt_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Sends the first nfall bits of a frame. lat = negedges from the stop-bit
  // falling PS2_CLK to evt_valid rising (-1 if it did not rise then).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nfall, output int lat);
    logic [10:0] bits;
    logic vb;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    lat = -1;
    for (int i = 0; i < nfall; i++) begin
      PS2_DAT = bits[i];
      cyc(H);
      PS2_CLK = 1'b0;
      vb = evt_valid;
      for (int k = 1; k <= H; k++) begin
        @(negedge CLOCK_50);
        if (i == 10 && lat < 0 && !vb && evt_valid) lat = k;
      end
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    cyc(H);
  endtask

  task automatic pop_one(input int exp_cnt);
    evt_ready = 1'b1;
    @(negedge CLOCK_50);
    evt_ready = 1'b0;
    check("pop_count", 32'(fifo_count), 32'(exp_cnt));
    check("pop_valid", 32'(evt_valid), 32'(exp_cnt != 0));
  endtask

  vec_t tbl[14];
  evt_t exp_q[$];

  initial begin
    int lat, e0, nerr_exp, nfr;
    logic [7:0] b;
    bit bad, ext_m, brk_m, done;
    evt_t ev, got;

    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 0, 1'b1, 8'h1C, 1'b0, 1'b0};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 0, 1'b1, 8'h1C, 1'b1, 1'b0};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{8'h75, 1'b0, 1'b0, 0, 1'b1, 8'h75, 1'b1, 1'b1};
    tbl[6]  = '{8'h1C, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{8'h32, 1'b0, 1'b0, 0, 1'b1, 8'h32, 1'b0, 1'b0};
    tbl[8]  = '{8'hE0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{8'hE0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{8'h6B, 1'b0, 1'b0, 0, 1'b1, 8'h6B, 1'b0, 1'b1};
    tbl[11] = '{8'hF0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{8'h1C, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{8'h2A, 1'b0, 1'b0, 0, 1'b1, 8'h2A, 1'b0, 1'b0};

    cyc(4);
    Resetn = 1'b1;
    cyc(2);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_code", 32'(evt_code), 0);

    // First-event latency: valid rises 4 negedges after the stop-bit fall.
    send_frame(8'h1C, 1'b0, 1'b0, 11, lat);
    check("latency", 32'(lat), 4);
    check("lat_count", 32'(fifo_count), 1);
    pop_one(0);

    // Table of frames, one event popped at a time.
    for (int i = 0; i < 14; i++) begin
      e0 = err_seen;
      send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, 11, lat);
      cyc(4);
      check($sformatf("tbl%0d_err", i), 32'(err_seen - e0), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_valid", i), 32'(evt_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_code", i), 32'(evt_code), 32'(tbl[i].exp_code));
      check($sformatf("tbl%0d_brk", i), 32'(evt_break), 32'(tbl[i].exp_brk));
      check($sformatf("tbl%0d_ext", i), 32'(evt_ext), 32'(tbl[i].exp_ext));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_count", i), 32'(fifo_count), 1);
        pop_one(0);
      end
    end

    // Falling PS2_CLK with DAT high in IDLE is ignored.
    e0 = err_seen;
    PS2_CLK = 1'b0; cyc(H); PS2_CLK = 1'b1; cyc(TMO + 20);
    check("glitch_err", 32'(err_seen - e0), 0);
    check("glitch_valid", 32'(evt_valid), 0);

    // Overflow: nine events into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 11, lat);
    cyc(4);
    check("ovf_count", 32'(fifo_count), 8);
    check("ovf_flag", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d_code", i), 32'(evt_code), 32'(i));
      pop_one(8 - i);
    end
    check("ovf_sticky", 32'(overflow), 1);
    err_clr = 1'b1; @(negedge CLOCK_50); err_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Timeout after E0 and four data bits; the ext flag must be dropped.
    send_frame(8'hE0, 1'b0, 1'b0, 11, lat);
    e0 = err_seen;
    send_frame(8'h55, 1'b0, 1'b0, 5, lat);
    cyc(TMO + 60);
    check("tmo_err", 32'(err_seen - e0), 1);
    check("tmo_valid", 32'(evt_valid), 0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, lat);
    cyc(4);
    check("tmo_next_code", 32'(evt_code), 32'h1C);
    check("tmo_next_ext", 32'(evt_ext), 0);
    pop_one(0);

    // Reset mid-frame: partial frame discarded, no error, no timeout later.
    e0 = err_seen;
    send_frame(8'hF0, 1'b0, 1'b0, 4, lat);
    Resetn = 1'b0; cyc(2); Resetn = 1'b1;
    cyc(TMO + 60);
    check("midrst_err", 32'(err_seen - e0), 0);
    check("midrst_valid", 32'(evt_valid), 0);
    check("midrst_count", 32'(fifo_count), 0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, lat);
    cyc(4);
    check("midrst_next", 32'({evt_valid, evt_ext, evt_break, evt_code}), 32'h41C);
    pop_one(0);

    // Random frames against a queue model, random consumer.
    ext_m = 1'b0; brk_m = 1'b0; nerr_exp = 0; done = 1'b0;
    e0 = err_seen;
    nfr = 40;
    fork
      begin
        for (int n = 0; n < nfr; n++) begin
          case ($urandom_range(0, 6))
            0: b = 8'hE0;
            1: b = 8'hF0;
            default: begin
              do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
            end
          endcase
          bad = ($urandom_range(0, 9) == 0);
          if (bad) begin
            nerr_exp++; ext_m = 1'b0; brk_m = 1'b0;
          end else if (b == 8'hE0) ext_m = 1'b1;
          else if (b == 8'hF0) brk_m = 1'b1;
          else begin
            ev.code = b; ev.brk = brk_m; ev.ext = ext_m;
            exp_q.push_back(ev);
            ext_m = 1'b0; brk_m = 1'b0;
          end
          send_frame(b, bad, 1'b0, 11, lat);
        end
        cyc(20);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge CLOCK_50);
          evt_ready = ($urandom_range(0, 1) == 1);
          if (evt_valid && evt_ready) begin
            got.code = evt_code; got.brk = evt_break; got.ext = evt_ext;
            if (exp_q.size() == 0) begin
              check("rnd_unexpected_evt", 32'(got.code), 32'h100);
            end else begin
              ev = exp_q.pop_front();
              check("rnd_code", 32'(got.code), 32'(ev.code));
              check("rnd_flags", 32'({got.ext, got.brk}), 32'({ev.ext, ev.brk}));
            end
          end
        end
        evt_ready = 1'b0;
      end
    join
    cyc(2);
    check("rnd_left", 32'(exp_q.size()), 0);
    check("rnd_count", 32'(fifo_count), 0);
    check("rnd_errs", 32'(err_seen - e0), 32'(nerr_exp));
    check("rnd_overflow", 32'(overflow), 0);
    check("err_pulse_width", 32'(err_wide), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
